// File: rtl/batch_norm_stream_pkg.sv
// Shared constants and helpers for the KWS batch-norm stream block.
// Holds the config-select encodings, default widths and the signed saturation helper.
package kws_bn_pkg;

   localparam int   DEF_DATA_W   = 32;
   localparam int   DEF_FRAC_W   = 24;
   localparam logic BN_CFG_SCALE = 1'b0;
   localparam logic BN_CFG_BIAS  = 1'b1;

   // Clamp a signed value into the range of a signed 'width'-bit word (width <= 64).
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) return max_v;
      if (value < min_v) return min_v;
      return value;
   endfunction

endpackage

// File: rtl/batch_norm_stream_if.sv
// Sample stream bundle for batch_norm_stream: input side and output side of the pipe.
// Handshake: a sample moves when valid and ready are both high on the same rising edge;
// valid and its payload must be held until that happens, ready may change at any time.
interface batch_norm_stream_if #(
   parameter int DATA_W = 32,
   parameter int CH_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CH_W-1:0]   in_ch;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_sat;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_ch, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_sat, out_err
   );

   modport slave (
      input  in_valid, in_data, in_ch, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_sat, out_err
   );
endinterface

// File: rtl/batch_norm_stream_param_rf.sv
// Per-channel {scale, bias} register file: one write port, one combinational read port.
// Reset loads identity (scale = 1.0, bias = 0); out-of-range addresses read 0 and never write.
module bn_param_rf
   import kws_bn_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int NUM_CH = 20,
   parameter int CH_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic              sel_i,
   input  logic [CH_W-1:0]   waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [CH_W-1:0]   raddr_i,
   output logic [DATA_W-1:0] rscale_o,
   output logic [DATA_W-1:0] rbias_o
);
   localparam logic [DATA_W-1:0] SCALE_ONE = DATA_W'(1) << FRAC_W;

   logic [DATA_W-1:0] scale_q [NUM_CH];
   logic [DATA_W-1:0] bias_q  [NUM_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            scale_q[i] <= SCALE_ONE;
            bias_q[i]  <= '0;
         end
      end else if (we_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (waddr_i == CH_W'(i)) begin
               if (sel_i == BN_CFG_SCALE) scale_q[i] <= wdata_i;
               else                       bias_q[i]  <= wdata_i;
            end
         end
      end
   end

   always_comb begin
      rscale_o = '0;
      rbias_o  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (raddr_i == CH_W'(i)) begin
            rscale_o = scale_q[i];
            rbias_o  = bias_q[i];
         end
      end
   end
endmodule

// File: rtl/batch_norm_stream.sv
// Streaming per-channel batch norm: y = sat(round(x*scale) + bias) over a 3-stage pipe
// with a global stall, runtime-loadable parameters and a sticky saturation counter.
module batch_norm_stream
   import kws_bn_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int NUM_CH = 20,
   parameter int CH_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bn_en,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [CH_W-1:0]   cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   batch_norm_stream_if.slave bus,
   output logic [CNT_W-1:0]  sat_count
);
   localparam logic [2*DATA_W-1:0] HALF_LSB = (2*DATA_W)'(1) << (FRAC_W - 1);

   logic                       adv;
   logic                       in_err;
   logic [DATA_W-1:0]          rf_scale;
   logic [DATA_W-1:0]          rf_bias;

   logic                       s1_valid_q, s1_en_q, s1_err_q;
   logic [DATA_W-1:0]          s1_x_q, s1_scale_q, s1_bias_q;
   logic [CH_W-1:0]            s1_ch_q;

   logic                       s2_valid_q, s2_en_q, s2_err_q;
   logic [DATA_W-1:0]          s2_x_q, s2_bias_q;
   logic [CH_W-1:0]            s2_ch_q;
   logic signed [2*DATA_W-1:0] s2_prod_q, s2_prod_d;

   logic                       out_valid_q, out_sat_q, out_err_q;
   logic [DATA_W-1:0]          out_data_q;
   logic [CH_W-1:0]            out_ch_q;
   logic                       out_sat_d;
   logic [DATA_W-1:0]          out_data_d;
   logic [CNT_W-1:0]           sat_count_q, sat_count_d;

   logic signed [2*DATA_W-1:0] rnd;
   logic signed [DATA_W:0]     r_clamp;
   logic signed [DATA_W+1:0]   sum;
   logic signed [63:0]         sum_sat;

   assign adv    = !out_valid_q || bus.out_ready;
   assign in_err = ({1'b0, bus.in_ch} >= (CH_W+1)'(NUM_CH));

   bn_param_rf #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (cfg_we),
      .sel_i    (cfg_sel),
      .waddr_i  (cfg_addr),
      .wdata_i  (cfg_wdata),
      .raddr_i  (bus.in_ch),
      .rscale_o (rf_scale),
      .rbias_o  (rf_bias)
   );

   assign s2_prod_d = (2*DATA_W)'($signed(s1_x_q)) * (2*DATA_W)'($signed(s1_scale_q));

   // The rounded product is pre-clamped to DATA_W+1 bits so the bias add fits DATA_W+2
   // bits; any product beyond that range saturates the final sum the same way regardless.
   always_comb begin
      rnd        = (s2_prod_q + $signed(HALF_LSB)) >>> FRAC_W;
      r_clamp    = (DATA_W+1)'(sat_signed(64'(rnd), DATA_W + 1));
      sum        = (DATA_W+2)'(r_clamp) + (DATA_W+2)'($signed(s2_bias_q));
      sum_sat    = sat_signed(64'(sum), DATA_W);
      out_data_d = DATA_W'(sum_sat);
      out_sat_d  = (sum_sat != 64'(sum));
      if (s2_err_q) begin
         out_data_d = '0;
         out_sat_d  = 1'b0;
      end else if (!s2_en_q) begin
         out_data_d = s2_x_q;
         out_sat_d  = 1'b0;
      end
   end

   always_comb begin
      sat_count_d = sat_count_q;
      if (out_valid_q && bus.out_ready && out_sat_q && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_en_q     <= 1'b0;
         s1_err_q    <= 1'b0;
         s1_x_q      <= '0;
         s1_ch_q     <= '0;
         s1_scale_q  <= '0;
         s1_bias_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_en_q     <= 1'b0;
         s2_err_q    <= 1'b0;
         s2_x_q      <= '0;
         s2_ch_q     <= '0;
         s2_bias_q   <= '0;
         s2_prod_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         sat_count_q <= sat_count_d;
         if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s1_en_q     <= bn_en;
            s1_err_q    <= in_err;
            s1_x_q      <= bus.in_data;
            s1_ch_q     <= bus.in_ch;
            s1_scale_q  <= rf_scale;
            s1_bias_q   <= rf_bias;
            s2_valid_q  <= s1_valid_q;
            s2_en_q     <= s1_en_q;
            s2_err_q    <= s1_err_q;
            s2_x_q      <= s1_x_q;
            s2_ch_q     <= s1_ch_q;
            s2_bias_q   <= s1_bias_q;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= s2_valid_q;
            out_data_q  <= out_data_d;
            out_ch_q    <= s2_ch_q;
            out_sat_q   <= out_sat_d;
            out_err_q   <= s2_err_q;
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.out_err   = out_err_q;
   assign sat_count     = sat_count_q;
endmodule

// File: tb/tb_batch_norm_stream.sv
// Self-checking bench for batch_norm_stream: directed vector table, hand-written corner
// sequences and a randomized stalled burst checked against an arithmetic reference model.
module tb_batch_norm_stream;
   import kws_bn_pkg::*;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 24;
   localparam int NUM_CH = 20;
   localparam int CH_W   = 5;
   localparam int CNT_W  = 16;
   localparam int W      = CH_W + 2 + DATA_W;   // {ch, err, sat, data}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              bn_en;
   logic              cfg_we;
   logic              cfg_sel;
   logic [CH_W-1:0]   cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic [CNT_W-1:0]  sat_count;

   batch_norm_stream_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

   batch_norm_stream #(
      .DATA_W (DATA_W), .FRAC_W (FRAC_W), .NUM_CH (NUM_CH), .CH_W (CH_W), .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bn_en     (bn_en),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .bus       (bus),
      .sat_count (sat_count)
   );

   // ---------------- scoreboard state and reference model ----------------
   int         checks = 0;
   int         errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   longint     scale_m [NUM_CH];
   longint     bias_m  [NUM_CH];
   int         accepted;
   bit         last_acc;
   bit         prev_stall;
   logic [W-1:0] prev_out;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         scale_m[c] = longint'(1) <<< FRAC_W;
         bias_m[c]  = 0;
      end
   endfunction

   // y = clamp(floor(x*scale/2^F + 1/2) + bias), computed in wide integer arithmetic.
   function automatic logic [W-1:0] ref_model(input logic [DATA_W-1:0] x,
                                              input logic [CH_W-1:0] ch, input bit en);
      longint xv, p, r, s;
      longint max_v, min_v;
      bit     sat;
      logic [DATA_W-1:0] y;
      max_v = (longint'(1) <<< (DATA_W - 1)) - 1;
      min_v = -(longint'(1) <<< (DATA_W - 1));
      if (int'(ch) >= NUM_CH) return {ch, 1'b1, 1'b0, {DATA_W{1'b0}}};
      if (!en) return {ch, 2'b00, x};
      xv  = longint'($signed(x));
      p   = xv * scale_m[ch];
      r   = (p + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
      s   = r + bias_m[ch];
      sat = 1'b0;
      if (s > max_v) begin s = max_v; sat = 1'b1; end
      else if (s < min_v) begin s = min_v; sat = 1'b1; end
      y = s[DATA_W-1:0];
      return {ch, 1'b0, sat, y};
   endfunction

   task automatic sb_step();
      logic [W-1:0] act;
      logic [W-1:0] e;
      act = {bus.out_ch, bus.out_err, bus.out_sat, bus.out_data};
      if (prev_stall) chk("stall_hold", {bus.out_valid, act}, {1'b1, prev_out});
      if (bus.out_valid && bus.out_ready) begin
         got_q.push_back(act);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none", act);
         end else begin
            e = exp_q.pop_front();
            chk("stream_out", act, e);
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = act;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input bit v, input logic [DATA_W-1:0] x, input logic [CH_W-1:0] ch,
                              input bit en, input bit we, input bit sel,
                              input logic [CH_W-1:0] addr, input logic [DATA_W-1:0] wd,
                              input bit ordy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = x;
      bus.in_ch     = ch;
      bn_en         = en;
      cfg_we        = we;
      cfg_sel       = sel;
      cfg_addr      = addr;
      cfg_wdata     = wd;
      bus.out_ready = ordy;
      #1;
      sb_step();
      last_acc = v && bus.in_ready;
      if (last_acc) begin
         exp_q.push_back(ref_model(x, ch, en));
         accepted++;
      end
      // Parameters change after this edge, so the sample above already used the old ones.
      if (we && int'(addr) < NUM_CH) begin
         if (sel == BN_CFG_BIAS) bias_m[addr]  = longint'($signed(wd));
         else                    scale_m[addr] = longint'($signed(wd));
      end
   endtask

   task automatic idle(input bit ordy);
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, ordy);
   endtask

   task automatic cfg_write(input bit sel, input logic [CH_W-1:0] addr, input logic [DATA_W-1:0] wd);
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b1, sel, addr, wd, 1'b1);
   endtask

   task automatic send(input logic [DATA_W-1:0] x, input logic [CH_W-1:0] ch, input bit en);
      drive_cycle(1'b1, x, ch, en, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         idle(1'b1);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
      idle(1'b1);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      cfg_we        = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_sat_count", sat_count, '0);
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      model_reset();
      prev_stall = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [CH_W-1:0]   ch;
      bit                en;
      bit                wr;
      logic [DATA_W-1:0] scale;
      logic [DATA_W-1:0] bias;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] exp_data;
      bit                exp_sat;
      bit                exp_err;
      int                exp_cnt;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] x, wd;
      logic [CH_W-1:0]   ch, addr;
      bit                en, pend, we, sel;
      int                cyc;

      tbl[0] = '{5'd3,  1'b1, 1'b1, 32'h0080_0000, 32'h0100_0000, 32'h0200_0000, 32'h0200_0000, 1'b0, 1'b0, 0};
      tbl[1] = '{5'd7,  1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h7F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
      tbl[2] = '{5'd8,  1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8100_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
      tbl[3] = '{5'd9,  1'b1, 1'b1, 32'h0080_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 2};
      tbl[4] = '{5'd9,  1'b1, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 2};
      tbl[5] = '{5'd10, 1'b1, 1'b1, 32'h0100_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 3};
      tbl[6] = '{5'd25, 1'b1, 1'b0, 32'h0,         32'h0,         32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 3};
      tbl[7] = '{5'd3,  1'b0, 1'b0, 32'h0,         32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 3};
      tbl[8] = '{5'd11, 1'b1, 1'b1, 32'hFF00_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 4};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_ch     = '0;
      bus.out_ready = 1'b1;
      bn_en         = 1'b1;
      cfg_we        = 1'b0;
      cfg_sel       = 1'b0;
      cfg_addr      = '0;
      cfg_wdata     = '0;
      accepted      = 0;
      prev_stall    = 1'b0;
      prev_out      = '0;
      model_reset();

      do_reset(3);
      #1;
      chk("reset_outs", {bus.out_valid, bus.out_data, bus.out_ch, bus.out_sat, bus.out_err, sat_count},
          '0);

      // Identity parameters on every channel, 3-cycle latency.
      for (int c = 0; c < NUM_CH; c++) begin
         send(32'h0180_0000, CH_W'(c), 1'b1);
         idle(1'b1);
         idle(1'b1);
         chk("lat_not_early", bus.out_valid, 1'b0);
         idle(1'b1);
         chk("lat_out", {bus.out_valid, bus.out_ch, bus.out_data}, {1'b1, CH_W'(c), 32'h0180_0000});
      end
      drain();

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].wr) begin
            cfg_write(BN_CFG_SCALE, tbl[i].ch, tbl[i].scale);
            cfg_write(BN_CFG_BIAS, tbl[i].ch, tbl[i].bias);
         end
         got_q.delete();
         send(tbl[i].x, tbl[i].ch, tbl[i].en);
         drain();
         chk("tbl_count", got_q.size(), 1);
         if (got_q.size() >= 1)
            chk("tbl_out", got_q[0], {tbl[i].ch, tbl[i].exp_err, tbl[i].exp_sat, tbl[i].exp_data});
         chk("tbl_sat_count", sat_count, CNT_W'(tbl[i].exp_cnt));
      end

      // Scale write in the same cycle as a ch5 sample is accepted.
      got_q.delete();
      drive_cycle(1'b1, 32'h0100_0000, 5'd5, 1'b1, 1'b1, BN_CFG_SCALE, 5'd5, 32'h0200_0000, 1'b1);
      send(32'h0100_0000, 5'd5, 1'b1);
      drain();
      chk("wr_race_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("wr_race_old", got_q[0], {5'd5, 2'b00, 32'h0100_0000});
         chk("wr_race_new", got_q[1], {5'd5, 2'b00, 32'h0200_0000});
      end

      // Random burst with random back-pressure and config traffic.
      got_q.delete();
      accepted = 0;
      pend     = 1'b0;
      cyc      = 0;
      x        = '0;
      ch       = '0;
      en       = 1'b1;
      while (accepted < 200 && cyc < 4000) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            x = $urandom();
            if ($urandom_range(0, 1) != 0) x = {{6{x[25]}}, x[25:0]};
            ch   = CH_W'($urandom_range(0, 21));
            en   = ($urandom_range(0, 7) != 0);
            pend = 1'b1;
         end
         we   = ($urandom_range(0, 9) == 0);
         sel  = $urandom_range(0, 1);
         addr = CH_W'($urandom_range(0, 22));
         wd   = $urandom();
         if ($urandom_range(0, 3) != 0) wd = {{6{wd[25]}}, wd[25:0]};
         drive_cycle(pend, x, ch, en, we, sel, addr, wd, 1'($urandom_range(0, 1)));
         if (last_acc) pend = 1'b0;
         cyc++;
      end
      drain();
      chk("burst_accepted", accepted, 200);
      chk("burst_outputs", got_q.size(), 200);

      // Reset in the middle of a stalled burst.
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, $urandom(), 5'd3, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      end
      do_reset(2);
      got_q.delete();
      send(32'h0040_0000, 5'd3, 1'b1);
      send(32'h7F00_0000, 5'd7, 1'b1);
      drain();
      chk("post_rst_count", got_q.size(), 2);
      if (got_q.size() >= 2) begin
         chk("post_rst_ch3", got_q[0], {5'd3, 2'b00, 32'h0040_0000});
         chk("post_rst_ch7", got_q[1], {5'd7, 2'b00, 32'h7F00_0000});
      end
      chk("post_rst_sat_count", sat_count, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
